hs_channel_arbiter: RTL
=======================

Name: hs_channel_arbiter

Overview:
- Clocked round-robin arbiter that shares one four-phase req/ack output channel among N four-phase requester channels. The output channel typically drives a fork stage.
- Sits at the boundary between the synchronous control domain and the asynchronous handshake pipeline.
- Synchronizes all asynchronous handshake inputs and sequences a complete four-phase cycle per grant.
- Drives a one-hot grant for the bundled-data mux, and runs a watchdog on the downstream acknowledge.

Parameters:
- N, 4, number of requester channels (N >= 2).
- SYNC_STAGES, 2, flop stages on each asynchronous input (req_i bits and ack_out_i); >= 2.
- TIMEOUT, 16, cycles allowed for each downstream ack transition before err_o sets; 0 disables the watchdog.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  N  four-phase requests, asynchronous to clk_i.
- ack_o  output  N  four-phase acknowledges, one per requester.
- req_out_o  output  1  shared downstream request.
- ack_out_i  input  1  shared downstream acknowledge, asynchronous to clk_i.
- grant_o  output  N  one-hot data-mux select; all zero when idle.
- grant_idx_o  output  $clog2(N)  binary index of current/last grantee.
- busy_o  output  1  high whenever the FSM is not IDLE.
- err_o  output  1  sticky watchdog error.
- clr_err_i  input  1  synchronous clear of err_o.

Behaviour:
- Reset (async, rst_ni low): all sync flops, ack_o, req_out_o, grant_o, grant_idx_o, busy_o and err_o go to 0; FSM goes to IDLE; last-grant pointer goes to N-1, so requester 0 wins first.
- Reset mid-handshake drops req_out_o/ack_o immediately; the surrounding system is reset together.
- req_s/ack_s are req_i/ack_out_i delayed by SYNC_STAGES flops. All decisions use only synchronized values.
- FSM, registered outputs, one transition per clock:
  - IDLE: if any req_s bit is high, select winner g = first set bit searching upward from (last+1) mod N with wrap. Set grant_o = onehot(g) and grant_idx_o = g; go to SETUP.
  - SETUP: one-cycle bundled-data setup for the mux. Then req_out_o <= 1; go to WAIT_ACK_UP.
  - WAIT_ACK_UP: when ack_s = 1, ack_o[g] <= 1; go to WAIT_REQ_DN.
  - WAIT_REQ_DN: when req_s[g] = 0, req_out_o <= 0; go to WAIT_ACK_DN.
  - WAIT_ACK_DN: when ack_s = 0, set ack_o[g] <= 0, grant_o <= 0 and last <= g; go to IDLE. grant_idx_o holds g.
- Latency:
  - req_i[g] rise to req_out_o rise: SYNC_STAGES+2 cycles.
  - ack_out_i rise to ack_o[g] rise: SYNC_STAGES+1.
  - req_i[g] fall to req_out_o fall: SYNC_STAGES+1.
  - ack_out_i fall to ack_o[g] fall: SYNC_STAGES+1.
- Minimum of one IDLE cycle between consecutive grants.
- Grant stability: grant_o is constant from SETUP through WAIT_ACK_DN. Non-granted ack_o bits stay 0. Requests from other channels arriving mid-cycle wait and are never lost.
- Simultaneous requests are resolved purely by round-robin order. A requester that drops req_i before its grant (protocol violation) is simply not selected if it is low at the IDLE sample.
- Watchdog: a counter clears on entry to WAIT_ACK_UP and to WAIT_ACK_DN, and increments each cycle in those states. On reaching TIMEOUT it sets err_o (sticky) and saturates. The FSM keeps waiting; the handshake is never aborted.
- clr_err_i clears err_o next cycle. If a timeout occurs in the same cycle as clr_err_i, set wins.
- busy_o = (state != IDLE), registered alongside the state.

Test Plan:
- Single request, N=4, SYNC_STAGES=2: req_i=4'b0001 with ack_out_i echoing req_out_o 3 cycles later.
  -> grant_o=0001 and req_out_o high 4 cycles after req_i; full four-phase cycle completes; grant_o returns to 0000; err_o stays 0.
- Round-robin fairness: hold req_i=4'b1111 with a well-behaved requester/downstream model.
  -> grant_idx_o sequence is 0,1,2,3,0; no channel granted twice consecutively.
- Wrap-around: last=3, then req_i=4'b1001 -> channel 0 granted; next grant is channel 3.
- Arrival mid-cycle: req_i[2] rises while channel 1 is in WAIT_ACK_UP.
  -> ack_o[2] stays 0 and grant_o stays 0010 until channel 1 finishes; channel 2 is granted on the next IDLE.
- Watchdog: TIMEOUT=16, downstream never raises ack_out_i.
  -> err_o rises 16 cycles after entering WAIT_ACK_UP. A late ack_out_i then still completes the cycle; clr_err_i pulse clears err_o.
- Async reset during WAIT_REQ_DN.
  -> ack_o, req_out_o, grant_o and busy_o are 0 without a clock edge; after release, req_i=4'b0010 is granted to channel 1.

Source files
------------

// File: rtl/hs_channel_arbiter_if.sv
// Handshake bundle between N four-phase requesters, the shared downstream
// channel and the arbiter's status/grant outputs.
interface hs_channel_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req_i;
  logic [N-1:0]  ack_o;
  logic          req_out_o;
  logic          ack_out_i;
  logic [N-1:0]  grant_o;
  logic [IW-1:0] grant_idx_o;
  logic          busy_o;
  logic          err_o;
  logic          clr_err_i;

  modport slave (
    input  req_i, ack_out_i, clr_err_i,
    output ack_o, req_out_o, grant_o, grant_idx_o, busy_o, err_o
  );

  modport master (
    output req_i, ack_out_i, clr_err_i,
    input  ack_o, req_out_o, grant_o, grant_idx_o, busy_o, err_o
  );
endinterface

// File: rtl/hs_channel_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack channel among N
// asynchronous requesters, with input synchronizers and an ack watchdog.
module hs_channel_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  hs_channel_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SETUP       = 3'd1,
    S_WAIT_ACK_UP = 3'd2,
    S_WAIT_REQ_DN = 3'd3,
    S_WAIT_ACK_DN = 3'd4
  } state_e;

  function automatic logic [N-1:0] onehot_f(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [N-1:0]        req_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [N-1:0]        req_s;
  logic                ack_s;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          req_out_q, req_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          win_found_s;
  logic [IW-1:0] win_idx_s;
  logic [CW-1:0] cnt_inc_s;
  logic          timeout_hit_s;

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Synchronizer chains for all asynchronous handshake inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        req_sync_q[s] <= '0;
      end
      ack_sync_q <= '0;
    end else begin
      req_sync_q[0] <= bus.req_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        req_sync_q[s] <= req_sync_q[s-1];
      end
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_out_i};
    end
  end

  // Round-robin pick: the smallest offset from last wins, so scan offsets downward.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int off = N; off >= 1; off--) begin
      cand        = (int'(last_q) + off) % N;
      win_found_s = win_found_s | req_s[cand];
      win_idx_s   = req_s[cand] ? IW'(cand) : win_idx_s;
    end
  end

  // Watchdog: saturating count while waiting on a downstream ack edge.
  always_comb begin
    cnt_inc_s     = (cnt_q == TO_MAX) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
    timeout_hit_s = (TIMEOUT > 0) && (cnt_q == TO_LAST) &&
                    ((state_q == S_WAIT_ACK_UP) || (state_q == S_WAIT_ACK_DN));
    err_d         = timeout_hit_s ? 1'b1 : (bus.clr_err_i ? 1'b0 : err_q);
  end

  // Handshake sequencer: next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    ack_d     = ack_q;
    req_out_d = req_out_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          grant_d = onehot_f(win_idx_s);
          idx_d   = win_idx_s;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        req_out_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_ACK_UP;
      end
      S_WAIT_ACK_UP: begin
        cnt_d = cnt_inc_s;
        if (ack_s) begin
          ack_d[idx_q] = 1'b1;
          state_d      = S_WAIT_REQ_DN;
        end else begin
          state_d = S_WAIT_ACK_UP;
        end
      end
      S_WAIT_REQ_DN: begin
        if (!req_s[idx_q]) begin
          req_out_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WAIT_ACK_DN;
        end else begin
          state_d = S_WAIT_REQ_DN;
        end
      end
      S_WAIT_ACK_DN: begin
        cnt_d = cnt_inc_s;
        if (!ack_s) begin
          ack_d[idx_q] = 1'b0;
          grant_d      = '0;
          last_d       = idx_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WAIT_ACK_DN;
        end
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        ack_d     = '0;
        req_out_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; last starts at N-1 so channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IW'(N - 1);
      ack_q     <= '0;
      req_out_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      req_out_q <= req_out_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.req_out_o   = req_out_q;
  assign bus.grant_o     = grant_q;
  assign bus.grant_idx_o = idx_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;

endmodule
